// File: rtl/tensor_set_buffer.sv
// DMA tensor port responder: operand sets A/B sunk from DMA, result set X sourced to DMA,
// each an independent circular FIFO with sticky error reporting and frame-ready flags.

module tensor_set_fifo #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic                 pop,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 rvalid,
  output logic [AW:0]          count,
  output logic [AW:0]          count_next,
  output logic                 underflow,
  output logic                 overflow
);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] P_ONE = AW'(1);

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 pop_ok;
  logic                 push_ok;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  always_comb begin
    pop_ok     = pop && (count != '0);
    push_ok    = push && ((count != FULL) || pop_ok);
    underflow  = pop && (count == '0);
    overflow   = push && !push_ok;
    count_next = count;
    if (push_ok && !pop_ok)
      count_next = count + C_ONE;
    else if (pop_ok && !push_ok)
      count_next = count - C_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      count  <= count_next;
      rvalid <= pop_ok;
      if (push_ok)
        wr_ptr <= wr_ptr + P_ONE;
      if (pop_ok) begin
        rdata  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + P_ONE;
      end
    end
  end
endmodule

module tensor_set_buffer #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           set,
  input  logic                 tensor_wen,
  input  logic                 tensor_ren,
  input  logic                 finished_transfer,
  input  logic [DATAWIDTH-1:0] mem_wdata,
  output logic [DATAWIDTH-1:0] mem_rdata,
  output logic                 mem_rvalid,
  input  logic                 a_pop,
  input  logic                 b_pop,
  output logic [DATAWIDTH-1:0] a_data,
  output logic [DATAWIDTH-1:0] b_data,
  output logic                 a_valid,
  output logic                 b_valid,
  input  logic                 x_push,
  input  logic [DATAWIDTH-1:0] x_data,
  output logic [AW:0]          a_count,
  output logic [AW:0]          b_count,
  output logic [AW:0]          x_count,
  output logic                 a_ready,
  output logic                 b_ready,
  output logic                 x_full,
  output logic [2:0]           err,
  input  logic                 err_clr
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic       wr_legal, rd_legal, illegal;
  logic [1:0] last_set;
  logic [AW:0] a_count_next, b_count_next, x_count_next;
  logic a_uf, a_of, b_uf, b_of, x_uf, x_of;
  logic [2:0] err_ev;

  // A beat is legal only when exactly one strobe is up and it targets a set it may touch.
  always_comb begin
    wr_legal = tensor_wen && !tensor_ren && !set[1];
    rd_legal = tensor_ren && !tensor_wen && (set == 2'd2);
    illegal  = (tensor_wen || tensor_ren) && !wr_legal && !rd_legal;
    err_ev   = {illegal, a_uf | b_uf | x_uf, a_of | b_of | x_of};
  end

  tensor_set_fifo #(.DATAWIDTH(DATAWIDTH), .DEPTH(DEPTH), .AW(AW)) u_a (
    .clk(clk), .rst(rst), .push(wr_legal && (set == 2'd0)), .wdata(mem_wdata),
    .pop(a_pop), .rdata(a_data), .rvalid(a_valid), .count(a_count),
    .count_next(a_count_next), .underflow(a_uf), .overflow(a_of));

  tensor_set_fifo #(.DATAWIDTH(DATAWIDTH), .DEPTH(DEPTH), .AW(AW)) u_b (
    .clk(clk), .rst(rst), .push(wr_legal && (set == 2'd1)), .wdata(mem_wdata),
    .pop(b_pop), .rdata(b_data), .rvalid(b_valid), .count(b_count),
    .count_next(b_count_next), .underflow(b_uf), .overflow(b_of));

  tensor_set_fifo #(.DATAWIDTH(DATAWIDTH), .DEPTH(DEPTH), .AW(AW)) u_x (
    .clk(clk), .rst(rst), .push(x_push), .wdata(x_data),
    .pop(rd_legal), .rdata(mem_rdata), .rvalid(mem_rvalid), .count(x_count),
    .count_next(x_count_next), .underflow(x_uf), .overflow(x_of));

  assign x_full = (x_count == FULL);

  // Ready set by finished_transfer outranks the clear from a final pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_set <= 2'd0;
      a_ready  <= 1'b0;
      b_ready  <= 1'b0;
      err      <= 3'b000;
    end else begin
      if (wr_legal || rd_legal)
        last_set <= set;
      if (finished_transfer && (last_set == 2'd0))
        a_ready <= 1'b1;
      else if ((a_count != '0) && (a_count_next == '0))
        a_ready <= 1'b0;
      if (finished_transfer && (last_set == 2'd1))
        b_ready <= 1'b1;
      else if ((b_count != '0) && (b_count_next == '0))
        b_ready <= 1'b0;
      err <= err_ev | (err & {3{~err_clr}});
    end
  end
endmodule

// File: tb/tb_tensor_set_buffer.sv
// Directed plus random bench for tensor_set_buffer, checked against a queue-based reference model.

module tb_tensor_set_buffer;
  logic       clk = 1'b0;
  logic       rst, tensor_wen, tensor_ren, finished_transfer;
  logic [1:0] set;
  logic [7:0] mem_wdata, mem_rdata, a_data, b_data, x_data;
  logic       mem_rvalid, a_pop, b_pop, a_valid, b_valid, x_push;
  logic [4:0] a_count, b_count, x_count;
  logic       a_ready, b_ready, x_full, err_clr;
  logic [2:0] err;

  int total = 0;
  int bad   = 0;

  logic [7:0] qa[$], qb[$], qx[$];
  logic [7:0] m_data [3];
  logic       m_vld  [3];
  logic [2:0] m_err;
  logic [1:0] m_last;
  logic       m_ra, m_rb;

  tensor_set_buffer #(.DATAWIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .set(set), .tensor_wen(tensor_wen), .tensor_ren(tensor_ren),
    .finished_transfer(finished_transfer), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .a_pop(a_pop), .b_pop(b_pop), .a_data(a_data), .b_data(b_data),
    .a_valid(a_valid), .b_valid(b_valid), .x_push(x_push), .x_data(x_data),
    .a_count(a_count), .b_count(b_count), .x_count(x_count), .a_ready(a_ready),
    .b_ready(b_ready), .x_full(x_full), .err(err), .err_clr(err_clr));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop happens before push, so an empty FIFO underflows yet still accepts the push,
  // and a full FIFO that is popped has room for the push.
  task automatic fifo_model(input int k, input logic push, input logic [7:0] wd,
                            input logic pop, inout logic [2:0] ev);
    logic [7:0] w[$];
    case (k)
      0: w = qa;
      1: w = qb;
      default: w = qx;
    endcase
    m_vld[k] = 1'b0;
    if (pop) begin
      if (w.size() > 0) begin
        m_data[k] = w.pop_front();
        m_vld[k]  = 1'b1;
      end else ev[1] = 1'b1;
    end
    if (push) begin
      if (w.size() < 16) w.push_back(wd);
      else ev[0] = 1'b1;
    end
    case (k)
      0: qa = w;
      1: qb = w;
      default: qx = w;
    endcase
  endtask

  task automatic model_update();
    logic wl, rl;
    logic [2:0] ev;
    int before_a, before_b;
    if (rst) begin
      qa.delete(); qb.delete(); qx.delete();
      for (int k = 0; k < 3; k++) begin
        m_data[k] = 8'h00;
        m_vld[k]  = 1'b0;
      end
      m_err = 3'b000; m_last = 2'd0; m_ra = 1'b0; m_rb = 1'b0;
      return;
    end
    wl = tensor_wen && !tensor_ren && (set < 2);
    rl = tensor_ren && !tensor_wen && (set == 2);
    ev = 3'b000;
    if ((tensor_wen || tensor_ren) && !wl && !rl) ev[2] = 1'b1;
    before_a = qa.size();
    before_b = qb.size();
    fifo_model(0, wl && (set == 0), mem_wdata, a_pop, ev);
    fifo_model(1, wl && (set == 1), mem_wdata, b_pop, ev);
    fifo_model(2, x_push, x_data, rl, ev);
    if (finished_transfer && m_last == 2'd0) m_ra = 1'b1;
    else if (before_a > 0 && qa.size() == 0) m_ra = 1'b0;
    if (finished_transfer && m_last == 2'd1) m_rb = 1'b1;
    else if (before_b > 0 && qb.size() == 0) m_rb = 1'b0;
    m_err = ev | (err_clr ? 3'b000 : m_err);
    if (wl || rl) m_last = set;
  endtask

  task automatic check_all();
    chk("a_count", a_count, qa.size());
    chk("b_count", b_count, qb.size());
    chk("x_count", x_count, qx.size());
    chk("a_valid", a_valid, m_vld[0]);
    chk("b_valid", b_valid, m_vld[1]);
    chk("mem_rvalid", mem_rvalid, m_vld[2]);
    chk("a_data", a_data, m_data[0]);
    chk("b_data", b_data, m_data[1]);
    chk("mem_rdata", mem_rdata, m_data[2]);
    chk("a_ready", a_ready, m_ra);
    chk("b_ready", b_ready, m_rb);
    chk("err", err, m_err);
    chk("x_full", x_full, qx.size() == 16);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    rst = 0; set = 0; tensor_wen = 0; tensor_ren = 0; finished_transfer = 0;
    mem_wdata = 0; a_pop = 0; b_pop = 0; x_push = 0; x_data = 0; err_clr = 0;
  endtask

  initial begin
    idle();
    #2;
    rst = 1; step(); step(); rst = 0;
    chk("reset_a_count", a_count, 0);
    chk("reset_err", err, 0);

    // Full A frame, ready, drain
    for (int i = 0; i < 16; i++) begin
      set = 0; tensor_wen = 1; mem_wdata = 8'h10 + 8'(i); step();
    end
    tensor_wen = 0; finished_transfer = 1; step(); finished_transfer = 0;
    chk("t1_a_count", a_count, 16);
    chk("t1_a_ready", a_ready, 1);
    for (int i = 0; i < 16; i++) begin
      a_pop = 1; step();
      chk("t1_a_data", a_data, 8'h10 + 8'(i));
      chk("t1_a_valid", a_valid, 1);
    end
    a_pop = 0;
    chk("t1_a_ready_drop", a_ready, 0);

    // Overflow on B
    for (int i = 0; i < 17; i++) begin
      set = 1; tensor_wen = 1; mem_wdata = 8'h20 + 8'(i); step();
    end
    tensor_wen = 0;
    chk("t2_b_count", b_count, 16);
    chk("t2_err", err, 3'b001);
    err_clr = 1; step(); err_clr = 0;
    chk("t2_err_clr", err, 0);
    for (int i = 0; i < 16; i++) begin b_pop = 1; step(); end
    b_pop = 0;

    // X readback with underflow on the fourth read
    for (int i = 0; i < 3; i++) begin x_push = 1; x_data = 8'hA1 + 8'(i); step(); end
    x_push = 0;
    for (int i = 0; i < 4; i++) begin
      set = 2; tensor_ren = 1; step();
      chk("t3_rvalid", mem_rvalid, i < 3);
    end
    tensor_ren = 0;
    chk("t3_err", err, 3'b010);
    chk("t3_rdata_hold", mem_rdata, 8'hA3);
    err_clr = 1; step(); err_clr = 0;

    // Wrap-around on A
    for (int i = 0; i < 16; i++) begin set = 0; tensor_wen = 1; mem_wdata = 8'h30 + 8'(i); step(); end
    tensor_wen = 0;
    for (int i = 0; i < 10; i++) begin a_pop = 1; step(); end
    a_pop = 0;
    for (int i = 0; i < 6; i++) begin set = 0; tensor_wen = 1; mem_wdata = 8'h40 + 8'(i); step(); end
    tensor_wen = 0;
    chk("t4_a_count", a_count, 12);
    for (int i = 0; i < 12; i++) begin
      a_pop = 1; step();
      chk("t4_a_order", a_data, (i < 6) ? 8'h3A + 8'(i) : 8'h40 + 8'(i - 6));
    end
    a_pop = 0;

    // Simultaneous push/pop on X
    for (int i = 0; i < 5; i++) begin x_push = 1; x_data = 8'h50 + 8'(i); step(); end
    set = 2; tensor_ren = 1; x_data = 8'h5F; step();
    chk("t5_x_count5", x_count, 5);
    x_push = 0;
    for (int i = 0; i < 5; i++) step();
    tensor_ren = 0;
    chk("t5_x_empty", x_count, 0);
    x_push = 1; tensor_ren = 1; x_data = 8'h66; step();
    x_push = 0; tensor_ren = 0;
    chk("t5_x_count1", x_count, 1);
    chk("t5_err_uf", err[1], 1);
    chk("t5_no_rvalid", mem_rvalid, 0);
    tensor_ren = 1; step(); tensor_ren = 0;
    err_clr = 1; step(); err_clr = 0;

    // Illegal beats and mid-fill reset
    set = 2; tensor_wen = 1; step(); tensor_wen = 0;
    chk("t6_err_set", err, 3'b100);
    err_clr = 1; step(); err_clr = 0;
    set = 0; tensor_wen = 1; tensor_ren = 1; mem_wdata = 8'h77; step();
    tensor_wen = 0; tensor_ren = 0;
    chk("t6_err_both", err, 3'b100);
    chk("t6_a_count", a_count, 0);
    for (int i = 0; i < 7; i++) begin set = 0; tensor_wen = 1; mem_wdata = 8'h80 + 8'(i); step(); end
    chk("t6_a_count7", a_count, 7);
    rst = 1; step(); rst = 0; tensor_wen = 0;
    chk("t6_rst_count", a_count, 0);
    chk("t6_rst_err", err, 0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      set = 2'($urandom_range(0, 3));
      tensor_wen = ($urandom_range(0, 2) == 0);
      tensor_ren = ($urandom_range(0, 3) == 0);
      mem_wdata = 8'($urandom);
      finished_transfer = ($urandom_range(0, 15) == 0);
      a_pop = ($urandom_range(0, 3) == 0);
      b_pop = ($urandom_range(0, 3) == 0);
      x_push = ($urandom_range(0, 2) == 0);
      x_data = 8'($urandom);
      err_clr = ($urandom_range(0, 19) == 0);
      step();
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tensor_set_buffer.md
Name: tensor_set_buffer

Overview:
- Responder for the DMA tensor port. It sits between the DMA engine and the compute array.
- It sinks DMA write beats (tensor_wen) into operand sets A and B. It sources result set X to the DMA on read beats (tensor_ren).
- Each set is an independent circular FIFO. Compute drains A/B and fills X.
- It flags when a complete operand frame is ready, based on the DMA finished_transfer pulse.

Parameters:
- DATAWIDTH, 8, width of every data word.
- DEPTH, 16, entries per set; power of two, >= 2.
- AW, $clog2(DEPTH), pointer width; count width is AW+1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- set  in  2  DMA set select: 0=A, 1=B, 2=X, 3=reserved
- tensor_wen  in  1  DMA write beat: push mem_wdata into set A or B
- tensor_ren  in  1  DMA read beat: pop set X
- finished_transfer  in  1  one-cycle pulse from DMA at end of transfer
- mem_wdata  in  DATAWIDTH  data from memory bus
- mem_rdata  out  DATAWIDTH  X word to memory bus
- mem_rvalid  out  1  mem_rdata valid, one-cycle pulse
- a_pop, b_pop  in  1 each  compute-side pop of A / B
- a_data, b_data  out  DATAWIDTH each  popped operand words
- a_valid, b_valid  out  1 each  pulse qualifying a_data / b_data
- x_push  in  1  compute-side push into X
- x_data  in  DATAWIDTH  result word
- a_count, b_count, x_count  out  AW+1 each  occupancy
- a_ready, b_ready  out  1 each  complete frame present
- x_full  out  1  X at DEPTH
- err  out  3  sticky {illegal_set, underflow, overflow}
- err_clr  in  1  clears err

Behaviour:
- Reset (synchronous): all pointers, counts, mem_rdata, a_data, b_data = 0. All valid/ready flags, err and last_set = 0. FIFO storage is not cleared.
- Reset mid-operation: everything is discarded on the next edge; the following cycle behaves as post-reset.
- DMA write: when tensor_wen=1 and set is 0 or 1, mem_wdata is written at wr_ptr of the selected set and wr_ptr/count advance at the edge. With set 2 or 3, the beat is ignored and err[2] is set.
- DMA read: when tensor_ren=1 and set=2 and X is not empty, mem_rdata = X[rd_ptr] registered and mem_rvalid=1 the next cycle; rd_ptr advances. With any other set, the beat is ignored and err[2] is set.
- tensor_wen and tensor_ren both high in one cycle: treated as illegal; neither acts; err[2] is set.
- Compute side: a_pop/b_pop have 1-cycle latency, with registered data and a valid pulse. x_push writes X at its wr_ptr.
- Pointers wrap modulo DEPTH. count = number of occupied entries, range 0..DEPTH inclusive.
- Push and pop on the same FIFO in the same cycle:
  - Both act and the count is unchanged.
  - If the FIFO was empty, only the push acts, the pop counts as underflow, and the count goes 0->1.
  - If the FIFO was full, both act, with no overflow.
- Push when full (and no simultaneous pop): word dropped, pointers held, err[0] set.
- Pop when empty: no valid pulse, data output held, pointers held, err[1] set.
- Holding registers:
  - mem_rdata, a_data and b_data hold their last value when not popping.
  - mem_rvalid, a_valid and b_valid are 0 except on the pulse cycle.
- last_set: a 2-bit register loaded with set on every legal tensor_wen/tensor_ren beat.
- Frame ready:
  - On finished_transfer=1: last_set=0 sets a_ready, last_set=1 sets b_ready, and last_set=2 has no flag effect.
  - a_ready clears on the edge where a_count goes to 0; b_ready likewise with b_count.
  - If finished_transfer and the final pop occur in the same cycle, the set takes priority.
- err: each bit is sticky and set by its event. err_clr=1 clears all bits, but an event in the same cycle wins for its bit.
- x_full = (x_count == DEPTH). This is combinational from the registered count.

Test Plan:
- Reset, then 16 DMA writes set=0 data 0x10..0x1F, then finished_transfer -> a_count=16, a_ready=1. Next, 16 a_pop -> a_data 0x10..0x1F, each 1 cycle after its pop; a_ready drops when a_count=0.
- 17th write to a full B -> b_count stays 16, err=3'b001. Then err_clr -> err=0.
- 3 x_push (0xA1, 0xA2, 0xA3), then tensor_ren set=2 for 4 cycles -> mem_rvalid pulses 3 times with 0xA1..0xA3. The 4th read sets err[1]; mem_rdata holds 0xA3.
- Wrap-around: fill A to 16, pop 10, write 6 -> a_count=12, and pop order is continuous across the pointer wrap.
- Simultaneous x_push and tensor_ren on X with count 5 -> count stays 5. On an empty X -> count=1, err[1]=1, no mem_rvalid.
- tensor_wen with set=2, and separately wen+ren together -> no FIFO change, err[2]=1. Assert rst mid-fill (a_count=7) -> all counts 0 and flags 0 the next cycle.
